// File: rtl/wash_ctrl_param.sv
// Parametrised washing-machine sequencer: fill, dose, agitate, drain, rinse passes, spin, done.
// Ports: clk/reset; panel+sensor inputs (start, door_closed, water_full, water_empty,
//        detergent_added); actuator outputs (door_lock, motor_on, valves), done, fault,
//        state_o (debug state code), rinse_left (rinse passes still to run).
module wash_ctrl_param #(
  parameter int NUM_RINSE    = 2,
  parameter int WASH_TICKS   = 16,
  parameter int RINSE_TICKS  = 8,
  parameter int SPIN_TICKS   = 12,
  parameter int FILL_TIMEOUT = 32,
  parameter int TW           = 8,
  // Keep at least one bit so NUM_RINSE=0 still yields a legal port.
  localparam int RW = (NUM_RINSE > 0) ? $clog2(NUM_RINSE + 1) : 1
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          start,
  input  logic          door_closed,
  input  logic          water_full,
  input  logic          water_empty,
  input  logic          detergent_added,
  output logic          door_lock,
  output logic          motor_on,
  output logic          fill_valve,
  output logic          drain_valve,
  output logic          detergent_valve,
  output logic          done,
  output logic          fault,
  output logic [3:0]    state_o,
  output logic [RW-1:0] rinse_left
);

  typedef enum logic [3:0] {
    S_IDLE    = 4'd0,
    S_FILL    = 4'd1,
    S_DOSE    = 4'd2,
    S_AGITATE = 4'd3,
    S_DRAIN   = 4'd4,
    S_SPIN    = 4'd5,
    S_DONE    = 4'd6,
    S_FAULT   = 4'd7
  } state_t;

  localparam logic [TW-1:0] TMAX = {TW{1'b1}};

  state_t        state, state_n;
  logic [TW-1:0] timer, timer_n;
  logic [RW-1:0] rinse_n;
  logic          phase, phase_n;     // 0 = main wash, 1 = rinse pass
  logic          drained, drained_n; // FAULT: water_empty already seen
  logic          locked;

  // Locked states that are still exposed to a door-open fault.
  assign locked = (state == S_FILL) || (state == S_DOSE) || (state == S_AGITATE) ||
                  (state == S_DRAIN) || (state == S_SPIN);

  always_comb begin
    state_n   = state;
    rinse_n   = rinse_left;
    phase_n   = phase;
    drained_n = drained;
    timer_n   = timer;
    case (state)
      S_IDLE: begin
        if (start && door_closed) begin
          state_n = S_FILL;
          phase_n = 1'b0;
          rinse_n = RW'(NUM_RINSE);
        end
      end
      S_FILL: begin
        // water_full checked first so it beats a same-cycle timeout.
        if (water_full)
          state_n = phase ? S_AGITATE : S_DOSE;
        else if (timer >= TW'(FILL_TIMEOUT - 1))
          state_n = S_FAULT;
      end
      S_DOSE: begin
        if (detergent_added) state_n = S_AGITATE;
      end
      S_AGITATE: begin
        if (timer >= (phase ? TW'(RINSE_TICKS - 1) : TW'(WASH_TICKS - 1)))
          state_n = S_DRAIN;
      end
      S_DRAIN: begin
        if (water_empty) begin
          if (rinse_left != '0) begin
            rinse_n = rinse_left - 1'b1;
            phase_n = 1'b1;
            state_n = S_FILL;
          end else begin
            state_n = S_SPIN;
          end
        end
      end
      S_SPIN: begin
        if (timer >= TW'(SPIN_TICKS - 1)) state_n = S_DONE;
      end
      S_DONE: begin
        if (!start) state_n = S_IDLE;
      end
      S_FAULT: begin
        if (water_empty) drained_n = 1'b1;
      end
      default: state_n = S_IDLE;
    endcase

    // Door opening while locked overrides whatever was decided above.
    if (locked && !door_closed) state_n = S_FAULT;
    if (state_n == S_FAULT && state != S_FAULT) drained_n = 1'b0;

    // Timer restarts on every state change and saturates instead of wrapping.
    if (state_n != state)
      timer_n = '0;
    else if ((state == S_FILL || state == S_AGITATE || state == S_SPIN) && timer != TMAX)
      timer_n = timer + 1'b1;
  end

  // Outputs are registered from the next-state decode so they line up with state.
  always_ff @(posedge clk) begin
    if (reset) begin
      state           <= S_IDLE;
      timer           <= '0;
      rinse_left      <= RW'(NUM_RINSE);
      phase           <= 1'b0;
      drained         <= 1'b0;
      door_lock       <= 1'b0;
      motor_on        <= 1'b0;
      fill_valve      <= 1'b0;
      drain_valve     <= 1'b0;
      detergent_valve <= 1'b0;
      done            <= 1'b0;
      fault           <= 1'b0;
    end else begin
      state           <= state_n;
      timer           <= timer_n;
      rinse_left      <= rinse_n;
      phase           <= phase_n;
      drained         <= drained_n;
      door_lock       <= (state_n != S_IDLE) && (state_n != S_DONE);
      motor_on        <= (state_n == S_AGITATE) || (state_n == S_SPIN);
      fill_valve      <= (state_n == S_FILL);
      drain_valve     <= (state_n == S_DRAIN) || (state_n == S_SPIN) ||
                         ((state_n == S_FAULT) && !drained_n);
      detergent_valve <= (state_n == S_DOSE);
      done            <= (state_n == S_DONE);
      fault           <= (state_n == S_FAULT);
    end
  end

  assign state_o = state;

endmodule

// File: tb/tb_wash_ctrl_param.sv
module tb_wash_ctrl_param;

  logic clk = 1'b0;
  logic reset, reset0;
  logic start, door_closed, water_full, water_empty, detergent_added;

  logic       door_lock, motor_on, fill_valve, drain_valve, detergent_valve, done, fault;
  logic [3:0] state_o;
  logic [1:0] rinse_left;

  logic       z_door_lock, z_motor_on, z_fill_valve, z_drain_valve, z_detergent_valve;
  logic       z_done, z_fault;
  logic [3:0] z_state_o;
  logic [0:0] z_rinse_left;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  wash_ctrl_param dut (
    .clk(clk), .reset(reset), .start(start), .door_closed(door_closed),
    .water_full(water_full), .water_empty(water_empty), .detergent_added(detergent_added),
    .door_lock(door_lock), .motor_on(motor_on), .fill_valve(fill_valve),
    .drain_valve(drain_valve), .detergent_valve(detergent_valve), .done(done),
    .fault(fault), .state_o(state_o), .rinse_left(rinse_left)
  );

  wash_ctrl_param #(.NUM_RINSE(0)) dut0 (
    .clk(clk), .reset(reset0), .start(start), .door_closed(door_closed),
    .water_full(water_full), .water_empty(water_empty), .detergent_added(detergent_added),
    .door_lock(z_door_lock), .motor_on(z_motor_on), .fill_valve(z_fill_valve),
    .drain_valve(z_drain_valve), .detergent_valve(z_detergent_valve), .done(z_done),
    .fault(z_fault), .state_o(z_state_o), .rinse_left(z_rinse_left)
  );

  task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      failures++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // Advance one clock; sample 1 time unit after the rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  // Packs the 1-bit outputs: {lock,motor,fill,drain,dose,done,fault}
  function automatic logic [7:0] outs();
    return {1'b0, door_lock, motor_on, fill_valve, drain_valve, detergent_valve, done, fault};
  endfunction

  initial begin
    reset = 1'b1; reset0 = 1'b1;
    start = 0; door_closed = 0; water_full = 0; water_empty = 0; detergent_added = 0;
    ticks(2);
    reset = 1'b0;
    #1;
    check("rst_state", state_o, 0);
    check("rst_outs", outs(), 0);
    check("rst_rinse", rinse_left, 2);

    // 1: full cycle with two rinses
    start = 1; door_closed = 1;
    tick();
    check("t1_fill", state_o, 1);
    check("t1_fill_outs", outs(), 8'b0101_0000);
    ticks(2);
    check("t1_fill_hold", state_o, 1);
    water_full = 1;
    tick();
    water_full = 0;
    check("t1_dose", state_o, 2);
    check("t1_dose_outs", outs(), 8'b0100_0100);
    tick();
    check("t1_dose_hold", state_o, 2);
    detergent_added = 1;
    tick();
    detergent_added = 0;
    check("t1_agit", state_o, 3);
    check("t1_agit_outs", outs(), 8'b0110_0000);
    ticks(15);
    check("t1_agit_last", state_o, 3);
    tick();
    check("t1_drain", state_o, 4);
    check("t1_drain_outs", outs(), 8'b0100_1000);
    for (int r = 1; r >= 0; r--) begin
      water_empty = 1;
      tick();
      water_empty = 0;
      check("t1_rinse_fill", state_o, 1);
      check("t1_rinse_left", rinse_left, 8'(r));
      water_full = 1;
      tick();
      water_full = 0;
      check("t1_rinse_nodose", state_o, 3);
      ticks(7);
      check("t1_rinse_agit_last", state_o, 3);
      tick();
      check("t1_rinse_drain", state_o, 4);
    end
    water_empty = 1;
    tick();
    water_empty = 0;
    check("t1_spin", state_o, 5);
    check("t1_spin_outs", outs(), 8'b0110_1000);
    ticks(11);
    check("t1_spin_last", state_o, 5);
    tick();
    check("t1_done", state_o, 6);
    check("t1_done_outs", outs(), 8'b0000_0010);
    tick();
    check("t1_done_hold", state_o, 6);
    start = 0;
    tick();
    check("t1_idle", state_o, 0);

    // 2: start with door open is ignored
    start = 1; door_closed = 0;
    ticks(2);
    check("t2_idle", state_o, 0);
    check("t2_unlocked", door_lock, 0);
    door_closed = 1;
    tick();
    check("t2_fill", state_o, 1);

    // 3: fill timeout after 32 cycles in FILL
    ticks(31);
    check("t3_fill_last", state_o, 1);
    tick();
    check("t3_fault", state_o, 7);
    check("t3_fault_outs", outs(), 8'b0100_1001);
    tick();
    check("t3_draining", drain_valve, 1);
    water_empty = 1;
    tick();
    water_empty = 0;
    check("t3_drained", drain_valve, 0);
    check("t3_fault_hold", fault, 1);
    start = 0;
    ticks(2);
    check("t3_fault_stay", state_o, 7);
    check("t3_lock_stay", door_lock, 1);
    reset = 1;
    tick();
    reset = 0;
    check("t3_reset", state_o, 0);
    check("t3_reset_fault", fault, 0);

    // 4: door opens at AGITATE cycle 5
    start = 1; door_closed = 1;
    tick();
    water_full = 1;
    tick();
    water_full = 0;
    detergent_added = 1;
    tick();
    detergent_added = 0;
    check("t4_agit", state_o, 3);
    ticks(4);
    check("t4_agit_c5", state_o, 3);
    door_closed = 0;
    tick();
    check("t4_fault", state_o, 7);
    check("t4_fault_outs", outs(), 8'b0100_1001);
    door_closed = 1;
    reset = 1;
    tick();
    reset = 0;

    // 5: reset during SPIN
    start = 1; water_full = 1; detergent_added = 1; water_empty = 1;
    begin
      int n;
      n = 0;
      while (state_o != 4'd5 && n < 200) begin
        tick();
        n++;
      end
      check("t5_reach_spin", state_o, 5);
    end
    water_full = 0; detergent_added = 0; water_empty = 0;
    tick();
    reset = 1;
    tick();
    check("t5_idle", state_o, 0);
    check("t5_outs", outs(), 0);
    check("t5_rinse", rinse_left, 2);

    // 6: NUM_RINSE=0 instance
    start = 0;
    reset0 = 0;
    #1;
    check("t6_rst", z_state_o, 0);
    check("t6_rinse", z_rinse_left, 0);
    start = 1; door_closed = 1;
    tick();
    check("t6_fill", z_state_o, 1);
    water_full = 1;
    tick();
    water_full = 0;
    detergent_added = 1;
    tick();
    detergent_added = 0;
    check("t6_agit", z_state_o, 3);
    ticks(16);
    check("t6_drain", z_state_o, 4);
    water_empty = 1;
    tick();
    water_empty = 0;
    check("t6_spin", z_state_o, 5);
    ticks(12);
    check("t6_done", z_state_o, 6);
    check("t6_done_out", z_done, 1);
    tick();
    check("t6_done_hold", z_state_o, 6);
    start = 0;
    tick();
    check("t6_idle", z_state_o, 0);
    check("t6_idle_done", z_done, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
